// File: rtl/bf2.sv
// bf2 -- second-generation Brainfuck execution core.
//
// Fetches one 8-bit instruction per cycle from a synchronous code ROM and
// operates on a tape held in a synchronous, write-through data RAM. A private
// loop-return stack holds the addresses that ']' jumps back to.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   code_addr / insn    next pc out; instruction at the current pc comes back
//   mem_addr            next tape pointer out
//   mem_din             cell at the current pointer
//   mem_wr / mem_dout   write strobe and data for the current cell
//   in_valid/in_data/in_ready     input byte stream (',')
//   out_valid/out_data/out_ready  output byte stream ('.')
//   halted              core stopped by HALT or a stack trap
//   error               00 none, 01 stack overflow, 10 stack underflow
//   sp                  stack occupancy
//
// Handshakes: a byte moves on a rising edge where valid and ready are both
// high. in_ready is only raised while a ',' executes and in_valid is high;
// out_valid is raised while a '.' executes and stays high, with out_data
// stable, until out_ready is seen. While waiting the core makes no progress.
module bf2 #(
    parameter int DATA_WIDTH  = 8,
    parameter int DADDR_WIDTH = 15,
    parameter int CADDR_WIDTH = 13,
    parameter int SP_WIDTH    = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [CADDR_WIDTH-1:0] code_addr,
    input  logic [7:0]             insn,
    output logic [DADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0]  mem_din,
    output logic                   mem_wr,
    output logic [DATA_WIDTH-1:0]  mem_dout,
    input  logic                   in_valid,
    input  logic [DATA_WIDTH-1:0]  in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [DATA_WIDTH-1:0]  out_data,
    input  logic                   out_ready,
    output logic                   halted,
    output logic [1:0]             error,
    output logic [SP_WIDTH:0]      sp
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_LJ   = 2'd1,
        ST_HALT = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam logic [CADDR_WIDTH-1:0] PC_ONE  = CADDR_WIDTH'(1);
    localparam logic [SP_WIDTH:0]      SP_FULL = {1'b1, {SP_WIDTH{1'b0}}};
    localparam logic [SP_WIDTH:0]      SP_ONE  = (SP_WIDTH+1)'(1);

    state_t                 state_q, state_d;
    logic [CADDR_WIDTH-1:0] pc_q, pc_d;
    logic [DADDR_WIDTH-1:0] maddr_q, maddr_d;
    logic [SP_WIDTH:0]      sp_q, sp_d;
    logic [1:0]             error_q, error_d;
    logic [4:0]             lj_hi_q, lj_hi_d;

    logic [CADDR_WIDTH-1:0] stack_q [2**SP_WIDTH];

    logic                   push_en;
    logic                   wr;
    logic                   in_rdy;
    logic                   out_vld;
    logic [DATA_WIDTH-1:0]  dout;

    // Step magnitude k = a[4:0] + 1, shared by pointer and cell arithmetic.
    logic [5:0]             k;
    logic [DATA_WIDTH-1:0]  k_cell;
    logic [DADDR_WIDTH-1:0] k_ptr;
    logic                   cell_nz;
    logic [SP_WIDTH-1:0]    top_idx;
    logic [CADDR_WIDTH-1:0] top;

    assign k       = {1'b0, insn[4:0]} + 6'd1;
    assign k_cell  = DATA_WIDTH'(k);
    assign k_ptr   = DADDR_WIDTH'(k);
    assign cell_nz = |mem_din;
    // With sp == 2^SP_WIDTH the low bits are zero, so this still lands on
    // the last entry.
    assign top_idx = sp_q[SP_WIDTH-1:0] - SP_WIDTH'(1);
    assign top     = stack_q[top_idx];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q + PC_ONE;
        maddr_d = maddr_q;
        sp_d    = sp_q;
        error_d = error_q;
        lj_hi_d = lj_hi_q;
        push_en = 1'b0;
        wr      = 1'b0;
        in_rdy  = 1'b0;
        out_vld = 1'b0;
        dout    = mem_din;

        case (state_q)
            ST_RUN: begin
                casez (insn)
                    8'b00??????: begin
                        maddr_d = insn[5] ? (maddr_q - k_ptr) : (maddr_q + k_ptr);
                    end
                    8'b01??????: begin
                        wr   = 1'b1;
                        dout = insn[5] ? (mem_din - k_cell) : (mem_din + k_cell);
                    end
                    8'b100?????: begin
                        if (insn[4:0] == 5'd0) begin
                            // ']' with an empty stack has nothing to return to.
                            if (sp_q == '0) begin
                                state_d = ST_ERR;
                                error_d = 2'b10;
                                pc_d    = pc_q;
                            end else if (cell_nz) begin
                                pc_d = top;
                            end else begin
                                sp_d = sp_q - SP_ONE;
                            end
                        end else if (cell_nz) begin
                            if (sp_q == SP_FULL) begin
                                state_d = ST_ERR;
                                error_d = 2'b01;
                                pc_d    = pc_q;
                            end else begin
                                push_en = 1'b1;
                                sp_d    = sp_q + SP_ONE;
                            end
                        end else begin
                            pc_d = pc_q + CADDR_WIDTH'(insn[4:0]) + PC_ONE;
                        end
                    end
                    8'b101?????: begin
                        lj_hi_d = insn[4:0];
                        state_d = ST_LJ;
                    end
                    8'b110?????: begin
                        if (in_valid) begin
                            in_rdy = 1'b1;
                            wr     = 1'b1;
                            dout   = in_data;
                        end else begin
                            pc_d = pc_q;
                        end
                    end
                    8'hff: begin
                        state_d = ST_HALT;
                        pc_d    = pc_q;
                    end
                    default: begin
                        // '.' (1110xxxx .. 11111110)
                        out_vld = 1'b1;
                        if (!out_ready) begin
                            pc_d = pc_q;
                        end
                    end
                endcase
            end
            ST_LJ: begin
                // insn is now the low offset byte L; pc_q points at it.
                state_d = ST_RUN;
                if (cell_nz) begin
                    if (sp_q == SP_FULL) begin
                        state_d = ST_ERR;
                        error_d = 2'b01;
                        pc_d    = pc_q;
                    end else begin
                        push_en = 1'b1;
                        sp_d    = sp_q + SP_ONE;
                    end
                end else begin
                    // Offset counts from the opcode byte (pc_q - 1), plus one,
                    // matching the short form's pc += n + 1.
                    pc_d = pc_q + CADDR_WIDTH'({lj_hi_q, insn});
                end
            end
            default: begin
                pc_d = pc_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            pc_q    <= '0;
            maddr_q <= '0;
            sp_q    <= '0;
            error_q <= 2'b00;
            lj_hi_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            maddr_q <= maddr_d;
            sp_q    <= sp_d;
            error_q <= error_d;
            lj_hi_q <= lj_hi_d;
        end
    end

    // Pushed value is always the address following the current byte.
    always_ff @(posedge clk) begin
        if (push_en && !reset) begin
            stack_q[sp_q[SP_WIDTH-1:0]] <= pc_q + PC_ONE;
        end
    end

    assign code_addr = reset ? '0 : pc_d;
    assign mem_addr  = reset ? '0 : maddr_d;
    assign mem_wr    = wr & ~reset;
    assign mem_dout  = dout;
    assign in_ready  = in_rdy & ~reset;
    assign out_valid = out_vld & ~reset;
    assign out_data  = mem_din;
    assign halted    = (state_q == ST_HALT) || (state_q == ST_ERR);
    assign error     = error_q;
    assign sp        = sp_q;

endmodule

// File: tb/tb_bf2.sv
// Directed testbench for bf2: behavioural code ROM and write-through tape RAM,
// hand-computed expectations for each program.
module tb_bf2;

    logic        clk;
    logic        reset;
    logic [12:0] code_addr;
    logic [7:0]  insn;
    logic [14:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        halted;
    logic [1:0]  error;
    logic [5:0]  sp;

    int checks   = 0;
    int failures = 0;

    logic [7:0] rom [8192];
    logic [7:0] ram [32768];

    int wr_cnt, in_cnt, out_cnt, ov_cnt;
    logic [5:0] sp_max;

    bf2 dut (
        .clk       (clk),
        .reset     (reset),
        .code_addr (code_addr),
        .insn      (insn),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_wr    (mem_wr),
        .mem_dout  (mem_dout),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .halted    (halted),
        .error     (error),
        .sp        (sp)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memories and event counters ----------------
    always @(posedge clk) begin
        insn <= rom[code_addr];
        if (reset) begin
            for (int i = 0; i < 32768; i++) ram[i] <= 8'h00;
            mem_din <= 8'h00;
            wr_cnt  <= 0;
            in_cnt  <= 0;
            out_cnt <= 0;
            ov_cnt  <= 0;
            sp_max  <= '0;
        end else begin
            if (mem_wr) begin
                ram[mem_addr] <= mem_dout;
                mem_din       <= mem_dout;
            end else begin
                mem_din <= ram[mem_addr];
            end
            if (mem_wr)                 wr_cnt  <= wr_cnt + 1;
            if (in_ready)               in_cnt  <= in_cnt + 1;
            if (out_valid && out_ready) out_cnt <= out_cnt + 1;
            if (out_valid)              ov_cnt  <= ov_cnt + 1;
            if (sp > sp_max)            sp_max  <= sp;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a negedge: holds reset and fills the ROM with HALT.
    task automatic start_prog();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        for (int i = 0; i < 8192; i++) rom[i] = 8'hff;
    endtask

    // Two edges under reset so the ROM presents rom[0] and the RAM is clear.
    task automatic release_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_until_halt(input int max, output int n);
        n = 0;
        while (!halted && n < max) begin
            @(negedge clk);
            n++;
        end
        check("halt_timeout", {31'd0, halted}, 32'd1);
    endtask

    int n;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        for (int i = 0; i < 8192; i++) rom[i] = 8'hff;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_code_addr", code_addr, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_strobes", {mem_wr, in_ready, out_valid, halted}, 0);
        check("rst_error", error, 0);
        check("rst_sp", sp, 0);

        // Cell arithmetic and pointer wrap: +2, -32, ptr-1 (wraps), +1, HALT
        start_prog();
        rom[0] = 8'h41; rom[1] = 8'h7f; rom[2] = 8'h20; rom[3] = 8'h40;
        release_reset();
        run_until_halt(50, n);
        check("arith_cycles", n, 5);
        check("arith_cell0", ram[0], 8'he2);
        check("arith_cell_wrap", ram[32767], 8'h01);
        check("arith_mem_addr", mem_addr, 15'h7fff);
        check("arith_pc", code_addr, 4);
        check("arith_writes", wr_cnt, 3);
        check("arith_error", error, 0);

        // Short loop "+3 [ - ]" then HALT
        start_prog();
        rom[0] = 8'h42; rom[1] = 8'h82; rom[2] = 8'h60; rom[3] = 8'h80;
        release_reset();
        run_until_halt(100, n);
        check("loop_cycles", n, 9);
        check("loop_cell", ram[0], 0);
        check("loop_writes", wr_cnt, 4);
        check("loop_sp", sp, 0);
        check("loop_sp_max", sp_max, 1);
        check("loop_pc", code_addr, 4);
        check("loop_error", error, 0);

        // Short '[' skipped with cell 0: jumps past the body
        start_prog();
        rom[0] = 8'h82; rom[1] = 8'h40; rom[2] = 8'h80;
        release_reset();
        run_until_halt(50, n);
        check("skip_pc", code_addr, 3);
        check("skip_writes", wr_cnt, 0);
        check("skip_sp", sp, 0);

        // Long jump taken with cell 0: 0xA1 0x05 at pc 10 -> pc 272
        start_prog();
        for (int i = 0; i < 10; i++) rom[i] = 8'h00;
        rom[10] = 8'ha1; rom[11] = 8'h05;
        rom[272] = 8'hff;
        release_reset();
        run_until_halt(100, n);
        check("lj_pc", code_addr, 272);
        check("lj_cycles", n, 13);
        check("lj_sp", sp, 0);
        check("lj_error", error, 0);

        // Long '[' with cell non-zero pushes and falls through
        start_prog();
        rom[0] = 8'h40; rom[1] = 8'ha1; rom[2] = 8'h05;
        release_reset();
        run_until_halt(50, n);
        check("lj_push_pc", code_addr, 3);
        check("lj_push_sp", sp, 1);

        // Input handshake: ',' stalls 4 cycles, then 0x5A arrives
        start_prog();
        rom[0] = 8'hc0;
        release_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("in_stall_pc", code_addr, 0);
            check("in_stall_ready", in_ready, 0);
        end
        in_valid = 1'b1;
        in_data  = 8'h5a;
        #1;
        check("in_ready_high", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        run_until_halt(20, n);
        check("in_cell", ram[0], 8'h5a);
        check("in_pulses", in_cnt, 1);
        check("in_pc", code_addr, 1);

        // Output backpressure: '.' of 0x33 with out_ready low 3 cycles
        start_prog();
        rom[0] = 8'h5f; rom[1] = 8'h52; rom[2] = 8'he0;
        release_reset();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("out_valid", out_valid, 1);
            check("out_data", out_data, 8'h33);
            if (i < 3) check("out_stall_pc", code_addr, 2);
            if (i == 3) out_ready = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        run_until_halt(20, n);
        check("out_valid_cycles", ov_cnt, 4);
        check("out_transfers", out_cnt, 1);
        check("out_pc", code_addr, 3);

        // Overflow: +1 then 33 nested '['
        start_prog();
        rom[0] = 8'h40;
        for (int i = 1; i <= 33; i++) rom[i] = 8'h81;
        release_reset();
        run_until_halt(100, n);
        check("ovf_cycles", n, 34);
        check("ovf_error", error, 2'b01);
        check("ovf_sp", sp, 32);
        check("ovf_pc", code_addr, 33);

        // Reset from ERR with a pending input byte
        reset    = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        check("rst2_in_ready", in_ready, 0);
        check("rst2_outputs", {halted, error, mem_wr, out_valid}, 0);
        check("rst2_addrs", {code_addr, mem_addr}, 0);
        check("rst2_sp", sp, 0);
        in_valid = 1'b0;

        // Underflow: ']' with cell 1 and empty stack
        start_prog();
        rom[0] = 8'h40; rom[1] = 8'h80;
        release_reset();
        run_until_halt(20, n);
        check("udf_nz_error", error, 2'b10);
        check("udf_nz_pc", code_addr, 1);

        // Underflow: ']' with cell 0 and empty stack
        start_prog();
        rom[0] = 8'h80;
        release_reset();
        run_until_halt(20, n);
        check("udf_z_error", error, 2'b10);
        check("udf_z_cycles", n, 1);

        // Reset mid-stall on ','
        start_prog();
        rom[0] = 8'hc0;
        release_reset();
        repeat (3) @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b1;
        #1;
        check("rst3_in_ready", in_ready, 0);
        @(negedge clk);
        check("rst3_code_addr", code_addr, 0);
        check("rst3_halted", halted, 0);
        in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
